// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU background engine: CPU register map,
// CTRL/MASK bit positions, fetch phases and the attribute quadrant helper.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_SCROLL = 3'd5;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam int CTRL_INC32   = 2;
  localparam int CTRL_BG_PT   = 4;
  localparam int CTRL_NMI     = 7;
  localparam int MASK_BG_LEFT = 1;
  localparam int MASK_BG      = 3;
  localparam int MASK_SPR     = 4;

  localparam logic [13:0] NT_BASE = 14'h2000;
  localparam logic [13:0] AT_BASE = 14'h23C0;

  // Fetch kind is (dot-1)[2:1]; the low phase bit picks request vs. capture.
  typedef enum logic [1:0] {
    PH_NT  = 2'd0,
    PH_AT  = 2'd1,
    PH_PTL = 2'd2,
    PH_PTH = 2'd3
  } fetch_phase_e;

  function automatic logic [1:0] attr_quadrant(input logic [7:0] at_byte,
                                               input logic [1:0] quad);
    logic [1:0] sel;
    case (quad)
      2'd0:    sel = at_byte[1:0];
      2'd1:    sel = at_byte[3:2];
      2'd2:    sel = at_byte[5:4];
      default: sel = at_byte[7:6];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ppu_scroll_regs.sv
// Loopy scroll registers v/t/x/w: CPU write decode plus the rendering-time
// coarse X / Y increments and horizontal / vertical copies from t.
module ppu_scroll_regs
  import ppu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        inc32,
  input  logic        inc_x,
  input  logic        inc_y,
  input  logic        copy_h,
  input  logic        copy_v,
  output logic [14:0] v,
  output logic [2:0]  fine_x
);

  logic [14:0] t;
  logic        w;
  logic [14:0] v_next, t_next;
  logic [2:0]  x_next;
  logic        w_next;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    v_next = v;
    t_next = t;
    x_next = fine_x;
    w_next = w;

    if (inc_x) begin
      if (v_next[4:0] == 5'd31) begin
        v_next[4:0] = 5'd0;
        v_next[10]  = ~v_next[10];
      end else begin
        v_next[4:0] = v_next[4:0] + 5'd1;
      end
    end

    if (inc_y) begin
      if (v_next[14:12] != 3'd7) begin
        v_next[14:12] = v_next[14:12] + 3'd1;
      end else begin
        v_next[14:12] = 3'd0;
        if (v_next[9:5] == 5'd29) begin
          v_next[9:5] = 5'd0;
          v_next[11]  = ~v_next[11];
        end else if (v_next[9:5] == 5'd31) begin
          v_next[9:5] = 5'd0;
        end else begin
          v_next[9:5] = v_next[9:5] + 5'd1;
        end
      end
    end

    if (copy_h) begin
      v_next[10]  = t[10];
      v_next[4:0] = t[4:0];
    end
    if (copy_v) begin
      v_next[14:11] = t[14:11];
      v_next[9:5]   = t[9:5];
    end

    // CPU writes to v come last so they override any rendering update.
    if (reg_wr) begin
      case (reg_addr)
        REG_CTRL: t_next[11:10] = reg_wdata[1:0];
        REG_SCROLL: begin
          if (!w) begin
            t_next[4:0] = reg_wdata[7:3];
            x_next      = reg_wdata[2:0];
            w_next      = 1'b1;
          end else begin
            t_next[14:12] = reg_wdata[2:0];
            t_next[9:5]   = reg_wdata[7:3];
            w_next        = 1'b0;
          end
        end
        REG_ADDR: begin
          if (!w) begin
            t_next[13:8] = reg_wdata[5:0];
            t_next[14]   = 1'b0;
            w_next       = 1'b1;
          end else begin
            t_next[7:0] = reg_wdata;
            v_next      = t_next;
            w_next      = 1'b0;
          end
        end
        REG_DATA: v_next = v + (inc32 ? 15'd32 : 15'd1);
        default: ;
      endcase
    end

    if (reg_rd && reg_addr == REG_STATUS) w_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      v      <= '0;
      t      <= '0;
      fine_x <= '0;
      w      <= 1'b0;
    end else begin
      v      <= v_next;
      t      <= t_next;
      fine_x <= x_next;
      w      <= w_next;
    end
  end

endmodule

// File: rtl/ppu_bg_pipeline.sv
// PPU background engine: dot/line timing, VBLANK/NMI, the 8-dot VRAM fetch
// sequence, pattern/attribute shifters and the registered pixel output.
module ppu_bg_pipeline
  import ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VISIBLE_LINES   = 240,
  parameter int ODD_FRAME_SKIP  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  status_rdata,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_rdata,
  output logic        pix_valid,
  output logic [4:0]  pix_index,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        nmi
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] PRE_LINE  = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
  localparam logic [8:0] VBL_LINE  = 9'(VISIBLE_LINES + 1);
  localparam bit         SKIP_EN   = (ODD_FRAME_SKIP != 0);

  logic [8:0]  dot, line;
  logic        frame_odd, vblank;
  logic        ctrl_nmi, ctrl_bg_pt, ctrl_inc32;
  logic        mask_bg_left, mask_bg, mask_spr;
  logic [14:0] v;
  logic [2:0]  fine_x;

  logic        render_en, visible_line, render_line, in_window, fetch_active;
  logic        status_rd, pixel_dot;
  logic [8:0]  dot_m1;
  logic [2:0]  phase;
  fetch_phase_e kind;
  logic [13:0] fetch_addr, addr_hold;
  logic [7:0]  nt_latch, pt_lo_latch;
  logic [1:0]  attr_latch;
  logic [15:0] sh_pt_lo, sh_pt_hi, sh_at_lo, sh_at_hi;
  logic [3:0]  bit_sel;
  logic [4:0]  pix_index_next;

  assign render_en    = mask_bg | mask_spr;
  assign visible_line = (line < VIS_LINES);
  assign render_line  = visible_line || (line == PRE_LINE);
  assign in_window    = (dot >= 9'd1 && dot <= 9'd256) || (dot >= 9'd321 && dot <= 9'd336);
  assign fetch_active = render_en && render_line && in_window;
  assign dot_m1       = dot - 9'd1;
  assign phase        = dot_m1[2:0];
  assign kind         = fetch_phase_e'(phase[2:1]);
  assign status_rd    = reg_rd && (reg_addr == REG_STATUS);
  assign pixel_dot    = visible_line && dot >= 9'd1 && dot <= 9'd256;

  assign status_rdata = {vblank, 7'b0};
  assign nmi          = vblank & ctrl_nmi;

  // Dot/line counters with the odd-frame short pre-render line.
  always_ff @(posedge clock) begin
    if (reset) begin
      dot       <= '0;
      line      <= PRE_LINE;
      frame_odd <= 1'b0;
    end else if (SKIP_EN && frame_odd && render_en && line == PRE_LINE && dot == SKIP_DOT) begin
      dot       <= '0;
      line      <= '0;
      frame_odd <= ~frame_odd;
    end else if (dot == LAST_DOT) begin
      dot <= '0;
      if (line == PRE_LINE) begin
        line      <= '0;
        frame_odd <= ~frame_odd;
      end else begin
        line <= line + 9'd1;
      end
    end else begin
      dot <= dot + 9'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_nmi     <= 1'b0;
      ctrl_bg_pt   <= 1'b0;
      ctrl_inc32   <= 1'b0;
      mask_bg_left <= 1'b0;
      mask_bg      <= 1'b0;
      mask_spr     <= 1'b0;
    end else if (reg_wr) begin
      if (reg_addr == REG_CTRL) begin
        ctrl_nmi   <= reg_wdata[CTRL_NMI];
        ctrl_bg_pt <= reg_wdata[CTRL_BG_PT];
        ctrl_inc32 <= reg_wdata[CTRL_INC32];
      end
      if (reg_addr == REG_MASK) begin
        mask_bg_left <= reg_wdata[MASK_BG_LEFT];
        mask_bg      <= reg_wdata[MASK_BG];
        mask_spr     <= reg_wdata[MASK_SPR];
      end
    end
  end

  // A STATUS read landing on the set cycle wins, so the flag never rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      vblank <= 1'b0;
    end else if (line == VBL_LINE && dot == 9'd1 && !status_rd) begin
      vblank <= 1'b1;
    end else if (status_rd || (line == PRE_LINE && dot == 9'd1)) begin
      vblank <= 1'b0;
    end
  end

  ppu_scroll_regs u_scroll (
    .clock     (clock),
    .reset     (reset),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .inc32     (ctrl_inc32),
    .inc_x     (fetch_active && phase == 3'd7),
    .inc_y     (render_en && render_line && dot == 9'd256),
    .copy_h    (render_en && render_line && dot == 9'd257),
    .copy_v    (render_en && line == PRE_LINE && dot >= 9'd280 && dot <= 9'd304),
    .v         (v),
    .fine_x    (fine_x)
  );

  always_comb begin
    fetch_addr = addr_hold;
    case (kind)
      PH_NT:  fetch_addr = NT_BASE | {2'b00, v[11:0]};
      PH_AT:  fetch_addr = AT_BASE | {2'b00, v[11:10], 10'b0}
                                   | {5'b0, v[9:7], 3'b0} | {11'b0, v[4:2]};
      PH_PTL: fetch_addr = {1'b0, ctrl_bg_pt, nt_latch, 1'b0, v[14:12]};
      PH_PTH: fetch_addr = {1'b0, ctrl_bg_pt, nt_latch, 1'b1, v[14:12]};
      default: ;
    endcase
  end

  // The request is combinational so read data arrives on the odd phase that captures it.
  assign vram_rd   = fetch_active && !phase[0];
  assign vram_addr = vram_rd ? fetch_addr : addr_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_hold   <= '0;
      nt_latch    <= '0;
      attr_latch  <= '0;
      pt_lo_latch <= '0;
      sh_pt_lo    <= '0;
      sh_pt_hi    <= '0;
      sh_at_lo    <= '0;
      sh_at_hi    <= '0;
    end else begin
      if (vram_rd) addr_hold <= fetch_addr;
      if (fetch_active) begin
        case (phase)
          3'd1: nt_latch    <= vram_rdata;
          3'd3: attr_latch  <= attr_quadrant(vram_rdata, {v[6], v[1]});
          3'd5: pt_lo_latch <= vram_rdata;
          default: ;
        endcase
        if (phase == 3'd7) begin
          // Shift and reload in one step; the PT hi byte is taken straight off the bus.
          sh_pt_lo <= {sh_pt_lo[14:7], pt_lo_latch};
          sh_pt_hi <= {sh_pt_hi[14:7], vram_rdata};
          sh_at_lo <= {sh_at_lo[14:7], {8{attr_latch[0]}}};
          sh_at_hi <= {sh_at_hi[14:7], {8{attr_latch[1]}}};
        end else begin
          sh_pt_lo <= {sh_pt_lo[14:0], 1'b0};
          sh_pt_hi <= {sh_pt_hi[14:0], 1'b0};
          sh_at_lo <= {sh_at_lo[14:0], 1'b0};
          sh_at_hi <= {sh_at_hi[14:0], 1'b0};
        end
      end
    end
  end

  assign bit_sel = 4'd15 - {1'b0, fine_x};

  always_comb begin
    pix_index_next = {1'b0, sh_at_hi[bit_sel], sh_at_lo[bit_sel],
                      sh_pt_hi[bit_sel], sh_pt_lo[bit_sel]};
    if (!render_en || !mask_bg || (!mask_bg_left && dot_m1 < 9'd8)) pix_index_next = 5'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_index <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      pix_valid <= pixel_dot;
      if (pixel_dot) begin
        pix_index <= pix_index_next;
        pix_x     <= dot_m1;
        pix_y     <= line;
      end
    end
  end

endmodule

// File: tb/tb_ppu_bg_pipeline.sv
// Directed bench for ppu_bg_pipeline with a shortened frame (16 lines, 4 visible)
// so that several whole frames fit in a short run.
module tb_ppu_bg_pipeline;
  import ppu_pkg::*;

  localparam int DOTS  = 341;
  localparam int LINES = 16;
  localparam int VIS   = 4;
  localparam int FRAME = DOTS * LINES;
  localparam int PRE   = LINES - 1;
  localparam int VBL   = VIS + 1;

  logic        clock = 1'b0;
  logic        reset, reg_wr, reg_rd;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata, status_rdata, vram_rdata;
  logic [13:0] vram_addr;
  logic        vram_rd, pix_valid, nmi;
  logic [4:0]  pix_index;
  logic [8:0]  pix_x, pix_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ppu_bg_pipeline #(
    .DOTS_PER_LINE   (DOTS),
    .LINES_PER_FRAME (LINES),
    .VISIBLE_LINES   (VIS),
    .ODD_FRAME_SKIP  (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .status_rdata (status_rdata),
    .vram_addr    (vram_addr),
    .vram_rd      (vram_rd),
    .vram_rdata   (vram_rdata),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .nmi          (nmi)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Every nametable entry is tile 1, every attribute byte is 0xE4,
  // tile 1 row 0 has lo plane 0xFF and hi plane 0x00.
  function automatic logic [7:0] vmem(input logic [13:0] a);
    if (a >= 14'h23C0 && a <= 14'h23FF) return 8'hE4;
    if (a >= 14'h2000 && a < 14'h23C0)  return 8'h01;
    if (a == 14'h0010)                  return 8'hFF;
    return 8'h00;
  endfunction

  always @(posedge clock) vram_rdata <= vram_rd ? vmem(vram_addr) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic status_read();
    reg_addr = REG_STATUS;
    reg_rd   = 1'b1;
    tick();
    reg_rd   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pos(input int l, input int d);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(dut.line == 9'(l) && dut.dot == 9'(d)) && n < 4 * FRAME);
    check($sformatf("reach_l%0d_d%0d", l, d), {dut.line, dut.dot}, {9'(l), 9'(d)});
  endtask

  task automatic wait_pix(input int x, input int y, output logic [4:0] idx);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(pix_valid && pix_x == 9'(x) && pix_y == 9'(y)) && n < 4 * FRAME);
    check($sformatf("pix_pos_x%0d", x), {pix_valid, pix_x, pix_y}, {1'b1, 9'(x), 9'(y)});
    idx = pix_index;
  endtask

  initial begin
    logic [4:0] idx;
    int t0, t1, t2;
    reset = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;

    // Reset state
    do_reset();
    check("rst_line", dut.line, PRE);
    check("rst_dot", dut.dot, 0);
    check("rst_status", status_rdata, 0);
    check("rst_nmi", nmi, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_vram_rd", vram_rd, 0);
    check("rst_vram_addr", vram_addr, 0);

    // SCROLL write pair
    reg_write(REG_SCROLL, 8'h7D);
    check("scroll1_w", dut.u_scroll.w, 1);
    check("scroll1_x", dut.u_scroll.fine_x, 5);
    check("scroll1_t_cx", dut.u_scroll.t[4:0], 15);
    reg_write(REG_SCROLL, 8'h5E);
    check("scroll2_t_fy", dut.u_scroll.t[14:12], 6);
    check("scroll2_t_cy", dut.u_scroll.t[9:5], 11);
    check("scroll2_w", dut.u_scroll.w, 0);
    reg_write(REG_SCROLL, 8'h00);
    check("scroll3_w", dut.u_scroll.w, 1);
    status_read();
    check("status_clr_w", dut.u_scroll.w, 0);

    // ADDR pair then DATA with +32 increment
    reg_write(REG_CTRL, 8'h04);
    reg_write(REG_ADDR, 8'h21);
    reg_write(REG_ADDR, 8'h08);
    check("addr_t", dut.u_scroll.t, 15'h2108);
    check("addr_v", dut.u_scroll.v, 15'h2108);
    reg_write(REG_DATA, 8'h00);
    check("data_inc32_v", dut.u_scroll.v, 15'h2128);

    // Background render, left column shown
    do_reset();
    reg_write(REG_ADDR, 8'h00);
    reg_write(REG_ADDR, 8'h00);
    reg_write(REG_MASK, 8'h0A);
    wait_pos(PRE, 321);
    check("nt_rd", vram_rd, 1);
    check("nt_addr", vram_addr, 14'h2000);
    tick();
    check("p1_rd", vram_rd, 0);
    check("p1_addr_hold", vram_addr, 14'h2000);
    tick();
    check("at_addr", vram_addr, 14'h23C0);
    tick(); tick();
    check("ptl_addr", vram_addr, 14'h0010);
    tick(); tick();
    check("pth_addr", vram_addr, 14'h0018);
    for (int x = 0; x < 8; x++) begin
      wait_pix(x, 0, idx);
      check($sformatf("show_idx_x%0d", x), idx, 5'h01);
    end
    wait_pix(8, 0, idx);
    check("show_idx_x8", idx, 5'h01);
    wait_pix(16, 0, idx);
    check("show_idx_x16_attr1", idx, 5'h05);

    // Left-8 clipping
    do_reset();
    reg_write(REG_ADDR, 8'h00);
    reg_write(REG_ADDR, 8'h00);
    reg_write(REG_MASK, 8'h08);
    for (int x = 0; x < 8; x++) begin
      wait_pix(x, 0, idx);
      check($sformatf("clip_idx_x%0d", x), idx, 5'h00);
    end
    wait_pix(8, 0, idx);
    check("clip_idx_x8", idx, 5'h01);

    // Frame timing, VBLANK and NMI
    do_reset();
    reg_write(REG_CTRL, 8'h80);
    reg_write(REG_MASK, 8'h08);
    wait_pos(0, 0);
    t0 = cyc;
    wait_pos(VBL, 1);
    check("vbl_before_set", status_rdata, 8'h00);
    tick();
    check("vbl_set", status_rdata, 8'h80);
    check("nmi_set", nmi, 1);
    status_read();
    check("vbl_read_clr", status_rdata, 8'h00);
    check("nmi_read_clr", nmi, 0);
    wait_pos(0, 0);
    t1 = cyc;
    check("frame_odd_len", t1 - t0, FRAME - 1);

    wait_pos(VBL, 1);
    reg_addr = REG_STATUS;
    reg_rd   = 1'b1;
    check("race_read_data", status_rdata, 8'h00);
    tick();
    reg_rd = 1'b0;
    check("race_suppressed", status_rdata, 8'h00);
    check("race_nmi", nmi, 0);
    wait_pos(0, 0);
    t2 = cyc;
    check("frame_even_len", t2 - t1, FRAME);

    wait_pos(VBL, 2);
    check("vbl_set2", status_rdata, 8'h80);
    wait_pos(PRE, 1);
    check("vbl_hold_pre", status_rdata, 8'h80);
    tick();
    check("vbl_pre_clr", status_rdata, 8'h00);
    check("nmi_pre_clr", nmi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
